vidcnt11: RTL
=============

VIDCNT11 -- requirements
Module: vidcnt11

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL change only on the rising edge of sys_clk.
REQ-002 sys_clk  input  1  system clock.
REQ-003 resetl  input  1  synchronous active-low reset.
REQ-004 cnten  input  1  count tick qualifier, one pixel or line advance per high cycle.
REQ-005 din_0..din_10  input  11  processor write data.
REQ-006 cntwr  input  1  count load strobe, level-sampled each cycle.
REQ-007 perwr  input  1  period register load strobe, level-sampled each cycle.
REQ-008 cntrd  input  1  count readback enable.
REQ-009 count_0..count_10  output  11  current count, feeds downstream compare registers.
REQ-010 wrap  output  1  one-cycle pulse, registered.
REQ-011 dout_N_out / dout_N_oe (N=0..10)  output  11+11  tri-state readback pair: value and enable.

Function
REQ-012 count SHALL be an 11-bit register; count_N SHALL be driven directly from the register, with no combinational path from any input.
REQ-013 period SHALL be an internal 11-bit register; perwr high SHALL load period <= din on the next edge.
REQ-014 cntwr high SHALL load count <= din on the next edge; this takes priority over cnten.
REQ-015 With cntwr low and cnten high, the block SHALL perform the wrap action if the compare field of count equals that of period (REQ-026/027); otherwise count <= count+1 modulo 2^11.
REQ-016 With cntwr low and cnten low, count SHALL hold.
REQ-017 wrap SHALL be high for exactly the one cycle following an edge on which a wrap action occurred; it SHALL be low otherwise, including after a cntwr load to 0.
REQ-018 On the cycle where perwr and a wrap compare coincide, the compare SHALL use the old period value.
REQ-019 When perwr and cntwr are high together, both registers SHALL load din.
REQ-020 A count above period SHALL increment through 0x7FF, then go to 0 by natural overflow; wrap SHALL NOT pulse on overflow.
REQ-021 period=0 SHALL wrap on every cnten cycle; count then stays at 0 and wrap is high continuously while cnten is high.
REQ-022 dout_N_out SHALL equal count_N; dout_N_oe SHALL equal cntrd combinationally.

Reset
REQ-023 While resetl is low at an edge, the block SHALL set count=0, period=0x7FF and wrap=0, overriding cntwr, perwr and cnten.
REQ-024 Reset asserted mid-line SHALL abort counting; counting SHALL resume from 0 on the first edge with resetl high and cnten high.
REQ-025 dout_N_oe SHALL follow cntrd even during reset, with dout_N_out reading 0.

Configuration
REQ-026 Without VIDCNT_HALFLINE_EN, the compare field SHALL be bits 0..10, and the wrap action SHALL be count <= 0.
REQ-027 With VIDCNT_HALFLINE_EN defined, the compare field SHALL be bits 0..9 only.
- Wrap action: bits 0..9 <= 0 and bit 10 toggles (half-line flag).
- Increments SHALL NOT carry out of bit 9; bit 9 overflow wraps bits 0..9 to 0 without touching bit 10.
- cntwr SHALL load all 11 bits.

Verification
REQ-028 Reset, then perwr with din=0x005, then cnten held high -> count sequence 0,1,2,3,4,5,0,1; wrap high only in the cycles where count=0 after 5.
REQ-029 count=0x003, cnten high, with cntwr din=0x100 on the same cycle -> next count=0x100, no wrap.
REQ-030 period=0x010 and count=0x010, with perwr din=0x020 on the same cnten cycle -> count=0, wrap pulses, and the next wrap occurs at 0x020.
REQ-031 period=0x7FF, load count=0x7FE, two cnten cycles -> 0x7FF then 0 with wrap; with period=0x100 and count=0x7FF -> 0 with no wrap.
REQ-032 VIDCNT_HALFLINE_EN, period=0x003, cnten held high from reset -> 0x000..0x003, 0x400..0x403, 0x000; wrap pulses at 0x400 and 0x000.
REQ-033 Reset pulled low while count=0x2A5 and period=0x010 -> count=0 and wrap=0 next cycle; period reads back 0x7FF behaviour (no wrap until 0x7FF); cntrd high -> dout_oe=1 and dout_out=count.

Source files
------------

// File: rtl/vidcnt11_if.sv
// vidcnt11_if -- bundle of the video counter's processor and count-side signals.
//   cnten    : count tick qualifier (one advance per high cycle)
//   din      : processor write data for count / period loads
//   cntwr    : count load strobe
//   perwr    : period load strobe
//   cntrd    : count readback enable
//   count    : current count value
//   wrap     : registered one-cycle pulse after a wrap action
//   dout_out : readback value bits
//   dout_oe  : readback output enables
// slave modport is the counter side, master modport is the controller side.
interface vidcnt11_if;
    logic        cnten;
    logic [10:0] din;
    logic        cntwr;
    logic        perwr;
    logic        cntrd;
    logic [10:0] count;
    logic        wrap;
    logic [10:0] dout_out;
    logic [10:0] dout_oe;

    modport slave (
        input  cnten, din, cntwr, perwr, cntrd,
        output count, wrap, dout_out, dout_oe
    );

    modport master (
        output cnten, din, cntwr, perwr, cntrd,
        input  count, wrap, dout_out, dout_oe
    );
endinterface

// File: rtl/vidcnt11.sv
// vidcnt11 -- 11-bit pixel/line counter with programmable wrap period.
//   sys_clk : system clock, all state changes on its rising edge
//   resetl  : synchronous active-low reset (count=0, period=0x7FF, wrap=0)
//   bus     : vidcnt11_if.slave (cnten, din, cntwr, perwr, cntrd in;
//             count, wrap, dout_out, dout_oe out)
// Optional feature: define VIDCNT_HALFLINE_EN to compare only bits 9..0 and
// use bit 10 as a half-line flag that toggles on every wrap.
module vidcnt11 (
    input  logic        sys_clk,
    input  logic        resetl,
    vidcnt11_if.slave   bus
);

    logic [10:0] r_count;
    logic [10:0] r_period;
    logic        r_wrap;

    logic        w_hit;
    logic [10:0] w_wrap_val;
    logic [10:0] w_inc_val;
    logic        w_wrap_act;

`ifdef VIDCNT_HALFLINE_EN
    // Bit 10 is a half-line flag: excluded from compare, toggled on wrap,
    // and never reached by carries out of bit 9.
    always_comb begin
        w_hit      = (r_count[9:0] == r_period[9:0]);
        w_wrap_val = {~r_count[10], 10'd0};
        w_inc_val  = {r_count[10], r_count[9:0] + 10'd1};
    end
`else
    always_comb begin
        w_hit      = (r_count == r_period);
        w_wrap_val = '0;
        w_inc_val  = r_count + 11'd1;
    end
`endif

    // cntwr wins over cnten, so a load never produces a wrap pulse.
    assign w_wrap_act = ~bus.cntwr & bus.cnten & w_hit;

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            r_count  <= '0;
            r_period <= '1;
            r_wrap   <= 1'b0;
        end else begin
            // Compare above uses the pre-edge period, so a coincident
            // perwr only affects later compares.
            if (bus.perwr)
                r_period <= bus.din;

            if (bus.cntwr)
                r_count <= bus.din;
            else if (bus.cnten)
                r_count <= w_hit ? w_wrap_val : w_inc_val;

            r_wrap <= w_wrap_act;
        end
    end

    assign bus.count    = r_count;
    assign bus.wrap     = r_wrap;
    assign bus.dout_out = r_count;
    assign bus.dout_oe  = {11{bus.cntrd}};

endmodule
